seg7l_blink_ctrl: RTL

- Sequential driver for the 7-seg "L" blink decoder's `en` input.
  - `en`=1: decoder displays "L".
  - `en`=0: decoder displays "0".
- Divides the DE0 50 MHz clock into equal on/off half-periods.
- Runs either a programmed number of blinks or continuously. Start/stop are single-cycle pulses.
- Sits between the board push-button/control logic and the decoder.

---
 rtl/seg7l_blink_ctrl_pkg.sv | 14 +
 rtl/half_period_timer.sv | 33 +++
 rtl/seg7l_blink_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/seg7l_blink_ctrl_pkg.sv
// Shared state encodings and default constants for the 7-seg "L" blink controller.
package seg7l_blink_ctrl_pkg;

    // One half-period of 0.5 s at the DE0 50 MHz clock
    localparam int unsigned DEF_TICK_DIV = 25_000_000;
    localparam int unsigned DEF_CNT_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

endpackage

// File: rtl/half_period_timer.sv
// Half-period timer: counts 0..TICK_DIV-1 while run is high and flags the last count.
// It only counts; the controlling FSM decides what the terminal count means.
module half_period_timer #(
    parameter int unsigned TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic nRST,
    input  logic clr,
    input  logic run,
    output logic tc
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);
    assign tc     = run && w_last;

    // Count with wrap at the terminal value; clear has priority over run
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= w_last ? '0 : r_cnt + TW'(1);
        end
    end

endmodule

// File: rtl/seg7l_blink_ctrl.sv
// Blink sequencer driving the 7-seg "L" decoder enable with equal on/off half-periods.
// Runs a programmed number of blinks (count != 0) or continuously (count == 0).
// Optional build macro SEG7L_BLINK_PAUSE_EN adds a pause input that freezes the sequence.
module seg7l_blink_ctrl
    import seg7l_blink_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV = DEF_TICK_DIV,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] count,
`ifdef SEG7L_BLINK_PAUSE_EN
    input  logic             pause,
`endif
    output logic             en,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_en;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_blinks;
    logic [CNT_W-1:0] r_count_lat;

    logic             w_done_nxt;
    logic             w_load;
    logic             w_blink_inc;
    logic             w_pause;
    logic             w_active;
    logic             w_tmr_clr;
    logic             w_tmr_run;
    logic             w_tc;

`ifdef SEG7L_BLINK_PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    assign w_active  = (r_state != ST_IDLE);
    // Timer sits at zero in IDLE and restarts on stop; it freezes under pause
    assign w_tmr_clr = !w_active || stop;
    assign w_tmr_run = w_active && !w_pause;

    half_period_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk  (clk),
        .nRST (nRST),
        .clr  (w_tmr_clr),
        .run  (w_tmr_run),
        .tc   (w_tc)
    );

    // Next-state and event decode; stop always wins, start is only heard in IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;
        w_blink_inc = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !stop) begin
                    w_state_nxt = ST_ON;
                    w_load      = 1'b1;
                end
            end
            ST_ON: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_tc) begin
                    w_state_nxt = ST_OFF;
                    w_blink_inc = 1'b1;
                end
            end
            ST_OFF: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_tc) begin
                    if ((r_count_lat != '0) && (r_blinks == r_count_lat)) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_ON;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, registered outputs and blink bookkeeping
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_state     <= ST_IDLE;
            r_en        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_blinks    <= '0;
            r_count_lat <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_en    <= (w_state_nxt == ST_ON);
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= w_done_nxt;
            if (w_load) begin
                r_count_lat <= count;
                r_blinks    <= '0;
            end else if (w_blink_inc) begin
                // Wraps freely in continuous mode; only compared when count != 0
                r_blinks <= r_blinks + CNT_W'(1);
            end
        end
    end

    assign en   = r_en;
    assign busy = r_busy;
    assign done = r_done;

endmodule
